// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan scheduler.
// Segment codes are active-low, bit order G F E D C B A p.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'h81, 8'hF3, 8'h49, 8'h61, 8'h33, 8'h25, 8'h05, 8'hF1,
    8'h01, 8'h31, 8'h11, 8'h07, 8'h8D, 8'h43, 8'h0D, 8'h1D
  };

  typedef enum logic [1:0] {
    ST_PARK,
    ST_BLANK,
    ST_SCAN
  } scan_state_t;

  function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_scheduler_hex_to_sseg.sv
// Hex nibble to active-low seven-segment code, decimal point left off.
module hex_to_sseg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_HEX[nib];
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Scan scheduler for four multiplexed hex digits: dwell, blanking, digit
// skipping and frame-aligned updates of the displayed set.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_PARK  | no digit enabled; display dark, always ready for an update
// ST_BLANK | dead time after a digit, all anodes off
// ST_SCAN  | digit idx driven for DWELL cycles
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int BLANK = 1
)
(
  input  logic        clk_out,
  input  logic        reset,
  input  logic        upd_valid,
  input  logic [15:0] upd_val,
  input  logic [3:0]  upd_dp,
  input  logic [3:0]  upd_en,
  output logic        upd_ready,
  output logic [7:0]  sseg,
  output logic [3:0]  AN,
  output logic        frame_start,
  output logic [1:0]  digit_idx
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);

  scan_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic          bnd_pend, bnd_n;
  logic          fs_n;
  logic [15:0]   val;
  logic [3:0]    dp;
  logic [3:0]    en;

  logic [1:0]    cand;
  logic [1:0]    nxt_idx;
  logic          wrap;
  logic          boundary;
  logic          last_blank;
  logic          xfer;
  logic [7:0]    seg_raw;

  hex_to_sseg u_dec (
    .nib (val[{idx, 2'b00} +: 4]),
    .seg (seg_raw)
  );

  // Next enabled digit strictly above idx, wrapping; landing at or below idx
  // means the frame is complete.
  always_comb begin
    cand    = idx;
    nxt_idx = idx;
    for (int k = 3; k >= 1; k--) begin
      cand = idx + 2'(k);
      if (en[cand]) nxt_idx = cand;
    end
    wrap = (nxt_idx <= idx);
  end

  assign last_blank = (state == ST_BLANK) && (cnt == BL_LAST);
  assign boundary   = bnd_pend || wrap;
  assign upd_ready  = (state == ST_PARK) || (last_blank && boundary);
  assign xfer       = upd_valid && upd_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    bnd_n   = bnd_pend;
    fs_n    = 1'b0;
    case (state)
      ST_SCAN: begin
        if (cnt == DW_LAST) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt == BL_LAST) begin
          cnt_n = '0;
          bnd_n = 1'b0;
          if (!boundary) begin
            state_n = ST_SCAN;
            idx_n   = nxt_idx;
          end else if (xfer && (upd_en == 4'b0000)) begin
            state_n = ST_PARK;
          end else begin
            state_n = ST_SCAN;
            fs_n    = 1'b1;
            idx_n   = xfer ? lowest_idx(upd_en) : lowest_idx(en);
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_PARK: begin
        if (xfer && (upd_en != 4'b0000)) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          bnd_n   = 1'b1;
        end
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
        bnd_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_out) begin
    if (reset) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= 2'd3;
      bnd_pend    <= 1'b1;
      frame_start <= 1'b0;
      val         <= 16'h0000;
      dp          <= 4'b0000;
      en          <= 4'b1111;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      bnd_pend    <= bnd_n;
      frame_start <= fs_n;
      if (xfer) begin
        val <= upd_val;
        dp  <= upd_dp;
        en  <= upd_en;
      end
    end
  end

  always_comb begin
    AN   = AN_OFF;
    sseg = SEG_OFF;
    if (state == ST_SCAN) begin
      AN   = ~(4'b0001 << idx);
      sseg = seg_raw & ~{7'b0, dp[idx]};
    end
  end

  assign digit_idx = idx;

endmodule
